kbd_pwm_bank: RTL and testbench

- Parametrised multi-channel PWM generator driven by decoded PS/2 keyboard bytes. It is the successor to the single-output make_pwm.
- Consumes the kbd_protocol byte strobe (scancode, flag) on the pixel-clock domain.
- Tracks make/break/extended prefixes and keeps one duty register per channel.
- Drives CHANNELS glitch-free PWM outputs with duty updates applied only at period boundaries.

---
 rtl/kbd_pwm_bank_if.sv | 8 +
 rtl/kbd_pwm_bank.sv | 203 ++++++++++++++++++++
 tb/tb_kbd_pwm_bank.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_pwm_bank_if.sv
// Decoded PS/2 byte strobe travelling from kbd_protocol into kbd_pwm_bank.
interface kbd_pwm_bank_if;
    logic       flag;
    logic [7:0] scancode;

    modport master (output flag, output scancode);
    modport slave  (input  flag, input  scancode);
endinterface

// File: rtl/kbd_pwm_bank.sv
// Multi-channel PWM bank steered by PS/2 make/break bytes.
// A small prefix tracker filters break codes and E0-extended keys. Per-channel
// duty registers are edited with saturating arithmetic. Each channel compares
// a free-running counter against a shadow copy of its duty. The shadow is only
// reloaded at the counter wrap, so an output never changes duty mid-period.
module kbd_pwm_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int STEP     = 16,
    parameter int PRESCALE = 4
) (
    input  logic                clk,
    input  logic                reset,
    kbd_pwm_bank_if.slave       kbd,
    output logic [CHANNELS-1:0] pwm,
    output logic [2:0]          sel_ch,
    output logic [WIDTH-1:0]    duty_mon,
    output logic                period_tick
);
    localparam int               PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] DUTY_MAX   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
    localparam logic [WIDTH:0]   STEP_W     = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0]   ONE_W      = (WIDTH + 1)'(1);
    localparam logic [3:0]       CH_LIMIT   = 4'(CHANNELS);

    typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} state_t;
    typedef enum logic [2:0] {ACT_NONE, ACT_SEL, ACT_INC, ACT_DEC,
                              ACT_ZERO, ACT_FULL, ACT_FINC, ACT_FDEC} act_t;

    // Add in WIDTH+1 bits so the carry is visible, then clamp to full scale.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a, input logic [WIDTH:0] d);
        logic [WIDTH:0] s;
        s = {1'b0, a} + d;
        if (s > {1'b0, DUTY_MAX}) sat_add = DUTY_MAX;
        else                      sat_add = s[WIDTH-1:0];
    endfunction

    // Subtract in WIDTH+1 bits; a borrow into the top bit means underflow.
    function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] a, input logic [WIDTH:0] d);
        logic [WIDTH:0] s;
        s = {1'b0, a} - d;
        if (s[WIDTH]) sat_sub = '0;
        else          sat_sub = s[WIDTH-1:0];
    endfunction

    // Number-row keys 1..8 map to channels 0..7; anything else returns 4'hF.
    function automatic logic [3:0] chan_index(input logic [7:0] code);
        case (code)
            8'h16:   chan_index = 4'd0;
            8'h1E:   chan_index = 4'd1;
            8'h26:   chan_index = 4'd2;
            8'h25:   chan_index = 4'd3;
            8'h2E:   chan_index = 4'd4;
            8'h36:   chan_index = 4'd5;
            8'h3D:   chan_index = 4'd6;
            8'h3E:   chan_index = 4'd7;
            default: chan_index = 4'hF;
        endcase
    endfunction

    // Action for a plain (non-prefixed) make code.
    function automatic act_t make_action(input logic [7:0] code);
        case (code)
            8'h16, 8'h1E, 8'h26, 8'h25,
            8'h2E, 8'h36, 8'h3D, 8'h3E: make_action = ACT_SEL;
            8'h3C:                      make_action = ACT_INC;
            8'h23:                      make_action = ACT_DEC;
            8'h1A:                      make_action = ACT_ZERO;
            8'h2B:                      make_action = ACT_FULL;
            default:                    make_action = ACT_NONE;
        endcase
    endfunction

    state_t             state_r, state_nxt_s;
    act_t               act_s;
    logic [3:0]         sel_idx_s;
    logic [2:0]         sel_r, sel_nxt_s;
    logic [WIDTH-1:0]   duty_r     [CHANNELS];
    logic [WIDTH-1:0]   duty_nxt_s [CHANNELS];
    logic [WIDTH-1:0]   shadow_r     [CHANNELS];
    logic [WIDTH-1:0]   shadow_nxt_s [CHANNELS];
    logic [WIDTH-1:0]   duty_mon_r, duty_mon_nxt_s;
    logic [PW-1:0]      presc_r, presc_nxt_s;
    logic [WIDTH-1:0]   cnt_r, cnt_nxt_s;
    logic               tick_s, wrap_s;
    logic [CHANNELS-1:0] pwm_r, pwm_nxt_s;
    logic               period_tick_r;

    // Prefix tracker: decide the next prefix state and which action this byte triggers.
    always_comb begin
        state_nxt_s = state_r;
        act_s       = ACT_NONE;
        if (kbd.flag) begin
            case (state_r)
                ST_IDLE: begin
                    if (kbd.scancode == 8'hF0) begin
                        state_nxt_s = ST_BRK;
                    end else if (kbd.scancode == 8'hE0) begin
                        state_nxt_s = ST_EXT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        act_s       = make_action(kbd.scancode);
                    end
                end
                ST_EXT: begin
                    if (kbd.scancode == 8'hF0) begin
                        state_nxt_s = ST_EXT_BRK;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        if (kbd.scancode == 8'h75)      act_s = ACT_FINC;
                        else if (kbd.scancode == 8'h72) act_s = ACT_FDEC;
                        else                            act_s = ACT_NONE;
                    end
                end
                ST_BRK, ST_EXT_BRK: state_nxt_s = ST_IDLE;
                default:            state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Apply the decoded action to the selection and the selected duty register.
    always_comb begin
        sel_idx_s = chan_index(kbd.scancode);
        if (act_s == ACT_SEL && sel_idx_s < CH_LIMIT) sel_nxt_s = sel_idx_s[2:0];
        else                                          sel_nxt_s = sel_r;
        for (int i = 0; i < CHANNELS; i++) begin
            duty_nxt_s[i] = duty_r[i];
            if (3'(i) == sel_r) begin
                case (act_s)
                    ACT_INC:  duty_nxt_s[i] = sat_add(duty_r[i], STEP_W);
                    ACT_DEC:  duty_nxt_s[i] = sat_sub(duty_r[i], STEP_W);
                    ACT_FINC: duty_nxt_s[i] = sat_add(duty_r[i], ONE_W);
                    ACT_FDEC: duty_nxt_s[i] = sat_sub(duty_r[i], ONE_W);
                    ACT_ZERO: duty_nxt_s[i] = '0;
                    ACT_FULL: duty_nxt_s[i] = DUTY_MAX;
                    default:  duty_nxt_s[i] = duty_r[i];
                endcase
            end else begin
                duty_nxt_s[i] = duty_r[i];
            end
        end
        duty_mon_nxt_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            duty_mon_nxt_s = duty_mon_nxt_s | (duty_nxt_s[i] & {WIDTH{3'(i) == sel_nxt_s}});
        end
    end

    // Timebase: prescaler, period counter, shadow reload at wrap and the next PWM levels.
    always_comb begin
        tick_s = (presc_r == PRESC_LAST);
        if (tick_s) begin
            presc_nxt_s = '0;
            cnt_nxt_s   = cnt_r + CNT_ONE;
        end else begin
            presc_nxt_s = presc_r + PRESC_ONE;
            cnt_nxt_s   = cnt_r;
        end
        wrap_s = tick_s && (cnt_r == DUTY_MAX);
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_nxt_s[i] = wrap_s ? duty_r[i] : shadow_r[i];
            pwm_nxt_s[i]    = (cnt_nxt_s < shadow_nxt_s[i]);
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            sel_r         <= 3'd0;
            duty_mon_r    <= '0;
            presc_r       <= '0;
            cnt_r         <= '0;
            pwm_r         <= '0;
            period_tick_r <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_r[i]   <= '0;
                shadow_r[i] <= '0;
            end
        end else begin
            state_r       <= state_nxt_s;
            sel_r         <= sel_nxt_s;
            duty_mon_r    <= duty_mon_nxt_s;
            presc_r       <= presc_nxt_s;
            cnt_r         <= cnt_nxt_s;
            pwm_r         <= pwm_nxt_s;
            period_tick_r <= wrap_s;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_r[i]   <= duty_nxt_s[i];
                shadow_r[i] <= shadow_nxt_s[i];
            end
        end
    end

    assign pwm         = pwm_r;
    assign sel_ch      = sel_r;
    assign duty_mon    = duty_mon_r;
    assign period_tick = period_tick_r;
endmodule

// File: tb/tb_kbd_pwm_bank.sv
// Bench for kbd_pwm_bank (CHANNELS=4, WIDTH=8, STEP=16, PRESCALE=1).
// A behavioural model tracks elapsed time, pending prefixes and duty values.
module tb_kbd_pwm_bank;
    localparam int NCH    = 4;
    localparam int PERIOD = 256;
    localparam int DMAX   = 255;
    localparam int STEPV  = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pwm;
    logic [2:0] sel_ch;
    logic [7:0] duty_mon;
    logic       period_tick;

    kbd_pwm_bank_if bus();

    kbd_pwm_bank #(.CHANNELS(NCH), .WIDTH(8), .STEP(STEPV), .PRESCALE(1)) dut (
        .clk(clk), .reset(reset), .kbd(bus.slave), .pwm(pwm),
        .sel_ch(sel_ch), .duty_mon(duty_mon), .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int         m_duty [NCH];
    int         m_shadow [NCH];
    int         m_sel;
    int         m_t;
    bit         pend_brk, pend_ext, m_tick;
    logic [3:0] m_pwm;

    task automatic model_make(input logic [7:0] c);
        logic [7:0] sel_codes [8];
        sel_codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};
        for (int k = 0; k < 8; k++) if (c == sel_codes[k] && k < NCH) m_sel = k;
        case (c)
            8'h3C:   m_duty[m_sel] = (m_duty[m_sel] + STEPV > DMAX) ? DMAX : m_duty[m_sel] + STEPV;
            8'h23:   m_duty[m_sel] = (m_duty[m_sel] - STEPV < 0) ? 0 : m_duty[m_sel] - STEPV;
            8'h1A:   m_duty[m_sel] = 0;
            8'h2B:   m_duty[m_sel] = DMAX;
            default: ;
        endcase
    endtask

    // Advance the model by one clock edge with the inputs sampled at that edge.
    task automatic model_edge(input bit rst_low, input bit f, input logic [7:0] c);
        if (rst_low) begin
            for (int k = 0; k < NCH; k++) begin m_duty[k] = 0; m_shadow[k] = 0; end
            m_sel = 0; m_t = 0; pend_brk = 0; pend_ext = 0; m_tick = 0; m_pwm = 4'b0000;
            return;
        end
        m_t++;
        m_tick = ((m_t % PERIOD) == 0);
        if (m_tick) for (int k = 0; k < NCH; k++) m_shadow[k] = m_duty[k];
        if (f) begin
            if (pend_brk) begin
                pend_brk = 0; pend_ext = 0;
            end else if (c == 8'hF0) begin
                pend_brk = 1; pend_ext = 0;
            end else if (pend_ext) begin
                pend_ext = 0;
                if (c == 8'h75 && m_duty[m_sel] < DMAX) m_duty[m_sel]++;
                if (c == 8'h72 && m_duty[m_sel] > 0) m_duty[m_sel]--;
            end else if (c == 8'hE0) begin
                pend_ext = 1;
            end else begin
                model_make(c);
            end
        end
        for (int k = 0; k < NCH; k++) m_pwm[k] = ((m_t % PERIOD) < m_shadow[k]);
    endtask

    task automatic step(input bit rst_low, input bit f, input logic [7:0] c);
        reset = ~rst_low; bus.flag = f; bus.scancode = c;
        @(posedge clk);
        model_edge(rst_low, f, c);
        #1;
        reset = 1'b1; bus.flag = 1'b0;
    endtask

    task automatic test_reset;
        int ticks;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'h00);
            checks++; if (pwm !== 4'b0000) begin failures++; $display("FAIL reset_pwm got=%b exp=0000", pwm); end
            checks++; if (sel_ch !== 3'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel_ch); end
            checks++; if (duty_mon !== 8'h00) begin failures++; $display("FAIL reset_duty_mon got=%h exp=00", duty_mon); end
            checks++; if (period_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", period_tick); end
        end
        ticks = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            step(1'b0, 1'b0, 8'h00);
            checks++; if (period_tick !== m_tick) begin failures++; $display("FAIL reset_tick_t%0d got=%b exp=%b", m_t, period_tick, m_tick); end
            if (period_tick === 1'b1) ticks++;
        end
        checks++; if (ticks != 2) begin failures++; $display("FAIL reset_tick_count got=%0d exp=2", ticks); end
    endtask

    task automatic test_coarse;
        bit found;
        int highs;
        logic [2:0] others;
        step(1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 8'h3C);
            checks++; if (duty_mon !== 8'(STEPV * (k + 1))) begin failures++; $display("FAIL coarse_step%0d got=%h exp=%h", k, duty_mon, 8'(STEPV * (k + 1))); end
            step(1'b0, 1'b0, 8'h00);
        end
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (period_tick === 1'b1) found = 1;
        end
        checks++; if (!found) begin failures++; $display("FAIL coarse_wait_tick got=timeout exp=tick"); end
        highs = 0; others = 3'b000;
        for (int i = 0; i < PERIOD; i++) begin
            if (i > 0) step(1'b0, 1'b0, 8'h00);
            if (pwm[0] === 1'b1) highs++;
            others = others | pwm[3:1];
        end
        checks++; if (highs != 48) begin failures++; $display("FAIL coarse_high_count got=%0d exp=48", highs); end
        checks++; if (others !== 3'b000) begin failures++; $display("FAIL coarse_other_ch got=%b exp=000", others); end
    endtask

    task automatic test_saturation;
        bit found;
        int highs2, mism;
        step(1'b0, 1'b1, 8'h26);
        checks++; if (sel_ch !== 3'd2) begin failures++; $display("FAIL sat_select got=%0d exp=2", sel_ch); end
        step(1'b0, 1'b1, 8'h2B);
        checks++; if (duty_mon !== 8'hFF) begin failures++; $display("FAIL sat_full got=%h exp=ff", duty_mon); end
        step(1'b0, 1'b1, 8'hE0);
        step(1'b0, 1'b1, 8'h75);
        checks++; if (duty_mon !== 8'hFF) begin failures++; $display("FAIL sat_fine_inc got=%h exp=ff", duty_mon); end
        step(1'b0, 1'b1, 8'h1A);
        checks++; if (duty_mon !== 8'h00) begin failures++; $display("FAIL sat_zero got=%h exp=00", duty_mon); end
        step(1'b0, 1'b1, 8'h23);
        checks++; if (duty_mon !== 8'h00) begin failures++; $display("FAIL sat_dec_floor got=%h exp=00", duty_mon); end
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (period_tick === 1'b1) found = 1;
        end
        checks++; if (!found) begin failures++; $display("FAIL sat_wait_tick got=timeout exp=tick"); end
        highs2 = 0; mism = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i > 0) step(1'b0, 1'b0, 8'h00);
            if (pwm[2] === 1'b1) highs2++;
            if (pwm !== m_pwm) mism++;
        end
        checks++; if (highs2 != 0) begin failures++; $display("FAIL sat_ch2_low got=%0d exp=0", highs2); end
        checks++; if (mism != 0) begin failures++; $display("FAIL sat_pwm_model got=%0d exp=0 bad cycles", mism); end
    endtask

    task automatic test_break_ext;
        step(1'b0, 1'b1, 8'hF0);
        step(1'b0, 1'b1, 8'h3C);
        checks++; if (duty_mon !== 8'h00) begin failures++; $display("FAIL brk_filter got=%h exp=00", duty_mon); end
        step(1'b0, 1'b1, 8'hE0);
        step(1'b0, 1'b1, 8'hF0);
        step(1'b0, 1'b1, 8'h75);
        checks++; if (duty_mon !== 8'h00) begin failures++; $display("FAIL ext_brk_filter got=%h exp=00", duty_mon); end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h3C);
        checks++; if (duty_mon !== 8'h10) begin failures++; $display("FAIL brk_back_idle got=%h exp=10", duty_mon); end
    endtask

    task automatic test_invalid_glitch;
        int highs, mism;
        step(1'b0, 1'b1, 8'h3D);
        checks++; if (sel_ch !== 3'd2) begin failures++; $display("FAIL invalid_sel got=%0d exp=2", sel_ch); end
        checks++; if (duty_mon !== 8'h10) begin failures++; $display("FAIL invalid_duty got=%h exp=10", duty_mon); end
        for (int i = 0; i < 300 && (m_t % PERIOD) != PERIOD - 1; i++) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h3C);
        checks++; if (period_tick !== 1'b1) begin failures++; $display("FAIL glitch_wrap_tick got=%b exp=1", period_tick); end
        checks++; if (duty_mon !== 8'h20) begin failures++; $display("FAIL glitch_wrap_duty got=%h exp=20", duty_mon); end
        highs = 0; mism = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i > 0) step(1'b0, i == 100, 8'h3C);
            if (pwm[2] === 1'b1) highs++;
            if (pwm !== m_pwm) mism++;
        end
        checks++; if (highs != 16) begin failures++; $display("FAIL glitch_old_period got=%0d exp=16", highs); end
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (i == 0) begin
                checks++; if (period_tick !== 1'b1) begin failures++; $display("FAIL glitch_next_tick got=%b exp=1", period_tick); end
            end
            if (pwm[2] === 1'b1) highs++;
            if (pwm !== m_pwm) mism++;
        end
        checks++; if (highs != 48) begin failures++; $display("FAIL glitch_new_period got=%0d exp=48", highs); end
        checks++; if (mism != 0) begin failures++; $display("FAIL glitch_pwm_model got=%0d exp=0 bad cycles", mism); end
    endtask

    task automatic test_reset_mid;
        step(1'b0, 1'b1, 8'hF0);
        step(1'b1, 1'b0, 8'h00);
        checks++; if (duty_mon !== 8'h00) begin failures++; $display("FAIL rstmid_clear got=%h exp=00", duty_mon); end
        step(1'b0, 1'b1, 8'h3C);
        checks++; if (duty_mon !== 8'h10) begin failures++; $display("FAIL rstmid_make got=%h exp=10", duty_mon); end
        checks++; if (sel_ch !== 3'd0) begin failures++; $display("FAIL rstmid_sel got=%0d exp=0", sel_ch); end
    endtask

    task automatic test_random;
        logic [7:0] pool [18];
        logic [7:0] c;
        int r, gap;
        bit rl;
        pool = '{8'hF0, 8'hE0, 8'h75, 8'h72, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                 8'h36, 8'h3D, 8'h3E, 8'h3C, 8'h23, 8'h1A, 8'h2B, 8'h3C, 8'h23};
        for (int n = 0; n < 700; n++) begin
            r = $urandom_range(0, 19);
            if (r < 18) c = pool[r];
            else        c = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 2);
            rl  = ($urandom_range(0, 99) == 0);
            for (int g = 0; g <= gap; g++) begin
                if (g == gap) step(rl, !rl, c);
                else          step(1'b0, 1'b0, 8'h00);
                checks++; if (pwm !== m_pwm) begin failures++; $display("FAIL rand_pwm t=%0d got=%b exp=%b", m_t, pwm, m_pwm); end
                checks++; if (period_tick !== m_tick) begin failures++; $display("FAIL rand_tick t=%0d got=%b exp=%b", m_t, period_tick, m_tick); end
                checks++; if (sel_ch !== 3'(m_sel)) begin failures++; $display("FAIL rand_sel t=%0d got=%0d exp=%0d", m_t, sel_ch, m_sel); end
                checks++; if (duty_mon !== 8'(m_duty[m_sel])) begin failures++; $display("FAIL rand_duty t=%0d got=%h exp=%h", m_t, duty_mon, 8'(m_duty[m_sel])); end
            end
        end
    endtask

    initial begin
        reset = 1'b0; bus.flag = 1'b0; bus.scancode = 8'h00;
        test_reset;
        test_coarse;
        test_saturation;
        test_break_ext;
        test_invalid_glitch;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
